alu_seq: RTL and testbench

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_pkg.sv | 21 ++
 rtl/alu_div.sv | 55 +++++
 rtl/alu_seq.sv | 112 +++++++++++
 tb/tb_alu_seq.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode and controller state encodings for the sequential ALU.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_MUL = 3'b010,
    OP_DIV = 3'b011,
    OP_NOT = 3'b100,
    OP_XOR = 3'b101,
    OP_OR  = 3'b110,
    OP_AND = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } state_e;

endpackage

// File: rtl/alu_div.sv
// Iterative restoring divider, one quotient bit per clock.
module alu_div #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
  logic [CW-1:0]    cnt_q;

  logic [WIDTH-1:0] rem_in, quo_in, dvs_in;
  logic [WIDTH:0]   shifted;
  logic             qbit;

  // The start cycle already performs the first step, so a WIDTH-bit divide
  // needs only WIDTH-1 further steps; quotient/remainder show the step result.
  always_comb begin
    rem_in    = start ? '0       : rem_q;
    quo_in    = start ? dividend : quo_q;
    dvs_in    = start ? divisor  : dvs_q;
    shifted   = {rem_in, quo_in[WIDTH-1]};
    qbit      = (shifted >= {1'b0, dvs_in});
    remainder = qbit ? (shifted[WIDTH-1:0] - dvs_in) : shifted[WIDTH-1:0];
    quotient  = {quo_in[WIDTH-2:0], qbit};
    done      = (cnt_q == CW'(1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
    end else if (start) begin
      rem_q <= remainder;
      quo_q <= quotient;
      dvs_q <= divisor;
      cnt_q <= CW'(WIDTH - 1);
    end else if (cnt_q != '0) begin
      rem_q <= remainder;
      quo_q <= quotient;
      cnt_q <= cnt_q - CW'(1);
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU with valid/ready handshake; DIV runs on the iterative divider.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       oc,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] f,
  output logic [WIDTH-1:0] rem,
  output logic             zf,
  output logic             cf,
  output logic             dz
);

  state_e state_q, state_d;
  op_e    op;

  logic               accept, div_go, div_done;
  logic [WIDTH-1:0]   div_quo, div_rem;
  logic [WIDTH:0]     sum, diff;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   res_f, res_rem;
  logic               res_cf, res_dz;

  assign op        = op_e'(oc);
  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign accept    = in_valid && in_ready;
  assign div_go    = accept && (op == OP_DIV) && (b != '0);

  alu_div #(.WIDTH(WIDTH)) u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (div_go),
    .dividend  (a),
    .divisor   (b),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  always_comb begin
    sum     = {1'b0, a} + {1'b0, b};
    diff    = {1'b0, a} - {1'b0, b};
    prod    = a * b;
    res_f   = '0;
    res_rem = '0;
    res_cf  = 1'b0;
    res_dz  = 1'b0;
    case (op)
      OP_ADD: begin res_f = sum[WIDTH-1:0];  res_cf = sum[WIDTH];  end
      OP_SUB: begin res_f = diff[WIDTH-1:0]; res_cf = diff[WIDTH]; end
      OP_MUL: begin
        res_f  = prod[WIDTH-1:0];
        res_cf = (prod[2*WIDTH-1:WIDTH] != '0);
      end
      // Only the divide-by-zero case completes here; other DIVs use the divider.
      OP_DIV: begin res_f = '1; res_rem = a; res_dz = 1'b1; end
      OP_NOT: res_f = ~a;
      OP_XOR: res_f = a ^ b;
      OP_OR:  res_f = a | b;
      OP_AND: res_f = a & b;
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept)    state_d = div_go ? ST_BUSY : ST_DONE;
      ST_BUSY: if (div_done)  state_d = ST_DONE;
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f   <= '0;
      rem <= '0;
      zf  <= 1'b0;
      cf  <= 1'b0;
      dz  <= 1'b0;
    end else if (accept && !div_go) begin
      f   <= res_f;
      rem <= res_rem;
      zf  <= (res_f == '0);
      cf  <= res_cf;
      dz  <= res_dz;
    end else if (state_q == ST_BUSY && div_done) begin
      f   <= div_quo;
      rem <= div_rem;
      zf  <= (div_quo == '0);
      cf  <= 1'b0;
      dz  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq at WIDTH = 8.
module tb_alu_seq;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready, out_valid, out_ready;
  logic [2:0] oc;
  logic [7:0] a, b, f, rem;
  logic       zf, cf, dz;

  int n_chk = 0;
  int n_bad = 0;

  alu_seq #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .oc        (oc),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .f         (f),
    .rem       (rem),
    .zf        (zf),
    .cf        (cf),
    .dz        (dz)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Issue one op, measure latency, check results, optionally stall the consumer.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [7:0] av,
                        input logic [7:0] bv, input logic [7:0] ef, input logic [7:0] er,
                        input logic ezf, input logic ecf, input logic edz,
                        input int exp_lat, input int hold);
    int lat;
    @(negedge clk);
    check({tag, "_in_ready"}, in_ready, 1);
    in_valid = 1; oc = op; a = av; b = bv;
    @(posedge clk); #1;
    in_valid = 0; oc = ~op; a = ~av; b = bv + 8'd1;
    lat = 0;
    do begin
      @(negedge clk); lat++;
    end while (!out_valid && lat < 40);
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_f"},   f,   ef);
    check({tag, "_rem"}, rem, er);
    check({tag, "_zf"},  zf,  ezf);
    check({tag, "_cf"},  cf,  ecf);
    check({tag, "_dz"},  dz,  edz);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1; oc = OP_ADD; a = 8'h33; b = 8'h44;
      @(negedge clk);
      check({tag, "_hold_valid"}, out_valid, 1);
      check({tag, "_hold_f"},     f,         ef);
      check({tag, "_hold_cf"},    cf,        ecf);
      check({tag, "_hold_rdy"},   in_ready,  0);
    end
    in_valid = 0; out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    check({tag, "_post_valid"}, out_valid, 0);
    check({tag, "_post_rdy"},   in_ready,  1);
  endtask

  initial begin
    logic [2:0] t_op [6];
    logic [7:0] t_a [6], t_b [6], t_f [6];
    int k, j, last;
    bit seen;

    rst_n = 0; in_valid = 0; out_ready = 0; oc = '0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_f", f, 0);
    check("rst_flags", {zf, cf, dz}, 0);
    rst_n = 1;

    //     tag       op      a      b      f      rem    zf cf dz lat hold
    run_op("add",    OP_ADD, 8'hF0, 8'h20, 8'h10, 8'h00, 0, 1, 0, 1, 0);
    run_op("sub",    OP_SUB, 8'd3,  8'd5,  8'hFE, 8'h00, 0, 1, 0, 1, 0);
    run_op("sub_nb", OP_SUB, 8'd5,  8'd3,  8'h02, 8'h00, 0, 0, 0, 1, 0);
    run_op("add_wr", OP_ADD, 8'hFF, 8'h01, 8'h00, 8'h00, 1, 1, 0, 1, 0);
    run_op("div",    OP_DIV, 8'd200,8'd7,  8'd28, 8'd4,  0, 0, 0, 8, 0);
    run_op("div_dz", OP_DIV, 8'd9,  8'd0,  8'hFF, 8'd9,  0, 0, 1, 1, 0);
    run_op("div_sm", OP_DIV, 8'd7,  8'd200,8'd0,  8'd7,  1, 0, 0, 8, 0);
    run_op("div_mx", OP_DIV, 8'hFF, 8'd1,  8'hFF, 8'd0,  0, 0, 0, 8, 0);
    run_op("or",     OP_OR,  8'h0F, 8'hF0, 8'hFF, 8'h00, 0, 0, 0, 1, 0);
    run_op("mul",    OP_MUL, 8'h10, 8'h10, 8'h00, 8'h00, 1, 1, 0, 1, 5);
    run_op("mul_lo", OP_MUL, 8'd12, 8'd11, 8'd132,8'h00, 0, 0, 0, 1, 0);

    // Back-to-back logic ops with the consumer always ready.
    t_op[0] = OP_XOR; t_a[0] = 8'hA5; t_b[0] = 8'h3C; t_f[0] = 8'h99;
    t_op[1] = OP_AND; t_a[1] = 8'hF0; t_b[1] = 8'h3C; t_f[1] = 8'h30;
    t_op[2] = OP_NOT; t_a[2] = 8'h5A; t_b[2] = 8'h00; t_f[2] = 8'hA5;
    t_op[3] = OP_XOR; t_a[3] = 8'h55; t_b[3] = 8'h55; t_f[3] = 8'h00;
    t_op[4] = OP_AND; t_a[4] = 8'hFF; t_b[4] = 8'h81; t_f[4] = 8'h81;
    t_op[5] = OP_NOT; t_a[5] = 8'hFF; t_b[5] = 8'h12; t_f[5] = 8'h00;
    k = 0; j = 0; last = 0;
    out_ready = 1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (out_valid && j < 6) begin
        check($sformatf("b2b_f%0d", j), f, t_f[j]);
        if (j > 0) check($sformatf("b2b_gap%0d", j), c - last, 2);
        last = c;
        j++;
      end
      if (in_ready && k < 6) begin
        in_valid = 1; oc = t_op[k]; a = t_a[k]; b = t_b[k]; k++;
      end else if (in_ready) begin
        in_valid = 0;
      end
    end
    in_valid = 0; out_ready = 0;
    check("b2b_count", j, 6);

    // Reset in the middle of a divide must abort it silently.
    @(negedge clk);
    in_valid = 1; oc = OP_DIV; a = 8'd200; b = 8'd7;
    @(posedge clk); #1;
    in_valid = 0;
    check("rdiv_busy", in_ready, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 0;
    #1;
    check("rdiv_rst_valid", out_valid, 0);
    check("rdiv_rst_rdy", in_ready, 1);
    check("rdiv_rst_f", f, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk); #1;
    check("rdiv_rel_rdy", in_ready, 1);
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    check("rdiv_no_result", seen, 0);

    run_op("post_rst", OP_ADD, 8'd1, 8'd2, 8'd3, 8'h00, 0, 0, 0, 1, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
